// File: rtl/munoc_evmon_pkg.sv
// -----------------------------------------------------------------------------
// munoc_evmon_pkg
// Shared definitions for the windowed event monitor: the controller state
// encoding, default parameter values and the saturating-increment helper
// used by every channel counter.
// -----------------------------------------------------------------------------
package munoc_evmon_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_COUNT = 1'b1
  } evmon_state_e;

  localparam int unsigned DEF_NUM_CH = 4;
  localparam int unsigned DEF_CNT_W  = 16;
  localparam int unsigned DEF_WINDOW = 500;

  // Counters up to 32 bits wide go through this helper; narrower callers
  // zero-extend on the way in and truncate on the way out.
  localparam int unsigned SAT_MAX_W = 32;

  function automatic logic [SAT_MAX_W-1:0] sat_inc(
    input logic [SAT_MAX_W-1:0] v,
    input logic [SAT_MAX_W-1:0] max_v
  );
    return (v >= max_v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/munoc_evmon_channel.sv
// -----------------------------------------------------------------------------
// munoc_evmon_channel
// One channel of the event window monitor: saturating hit and miss counters.
// The snapshot outputs present the count including the current cycle's event,
// so the top can capture them on the window's last cycle while the counters
// reload to zero.
// Optional MUNOC_EVMON_PEAK_EN: per-channel peak of loaded hit snapshots.
//
// Ports:
//   clk, rstnn     clock, asynchronous active-low reset
//   i_clear        synchronous clear of all state
//   i_advance      enabled cycle: events are counted
//   i_snap         window end: counters reload to zero
//   i_ev_valid     event qualifier
//   i_ev_hit       event class (1 = hit, 0 = miss)
//   o_snap_hit     hit count including this cycle's event
//   o_snap_miss    miss count including this cycle's event
//   i_load         (peak build) snapshot is loaded into the report register
//   o_peak_hit     (peak build) running maximum of loaded hit counts
// -----------------------------------------------------------------------------
module munoc_evmon_channel
  import munoc_evmon_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rstnn,
  input  logic             i_clear,
  input  logic             i_advance,
  input  logic             i_snap,
  input  logic             i_ev_valid,
  input  logic             i_ev_hit,
  output logic [CNT_W-1:0] o_snap_hit,
  output logic [CNT_W-1:0] o_snap_miss
`ifdef MUNOC_EVMON_PEAK_EN
  ,
  input  logic             i_load,
  output logic [CNT_W-1:0] o_peak_hit
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] r_hit;
  logic [CNT_W-1:0] r_miss;
  logic             w_hit_inc;
  logic             w_miss_inc;
  logic [CNT_W-1:0] w_hit_nxt;
  logic [CNT_W-1:0] w_miss_nxt;

  always_comb begin
    w_hit_inc  = i_advance & i_ev_valid & i_ev_hit;
    w_miss_inc = i_advance & i_ev_valid & ~i_ev_hit;
    w_hit_nxt  = r_hit;
    w_miss_nxt = r_miss;
    if (w_hit_inc)
      w_hit_nxt = CNT_W'(sat_inc(SAT_MAX_W'(r_hit), SAT_MAX_W'(CNT_MAX)));
    if (w_miss_inc)
      w_miss_nxt = CNT_W'(sat_inc(SAT_MAX_W'(r_miss), SAT_MAX_W'(CNT_MAX)));
  end

  assign o_snap_hit  = w_hit_nxt;
  assign o_snap_miss = w_miss_nxt;

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      r_hit  <= '0;
      r_miss <= '0;
    end else if (i_clear || i_snap) begin
      r_hit  <= '0;
      r_miss <= '0;
    end else begin
      r_hit  <= w_hit_nxt;
      r_miss <= w_miss_nxt;
    end
  end

`ifdef MUNOC_EVMON_PEAK_EN
  logic [CNT_W-1:0] r_peak;

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      r_peak <= '0;
    end else if (i_clear) begin
      r_peak <= '0;
    end else if (i_load && (w_hit_nxt > r_peak)) begin
      r_peak <= w_hit_nxt;
    end
  end

  assign o_peak_hit = r_peak;
`endif

endmodule

// File: rtl/munoc_event_window_monitor.sv
// -----------------------------------------------------------------------------
// munoc_event_window_monitor
// Multi-channel windowed hit/miss monitor. Counts qualified events per channel
// over WINDOW enabled cycles, snapshots the counts into a report register
// offered with valid/ready, and restarts. A snapshot arriving while an
// unaccepted report is pending is discarded and flagged in sticky
// report_drop.
// Optional feature macro: MUNOC_EVMON_PEAK_EN adds report_peak_hit.
//
// Ports:
//   clk, rstnn       clock, asynchronous active-low reset
//   clear            synchronous clear of all state
//   enable           window and counters advance only when high
//   event_valid      per-channel event qualifier            [NUM_CH]
//   event_hit        per-channel class, 1 = hit, 0 = miss    [NUM_CH]
//   report_valid     snapshot available
//   report_ready     consumer accepts snapshot
//   report_hit       hit counts, channel i at [i*CNT_W +: CNT_W]
//   report_miss      miss counts, same packing
//   report_drop      sticky: a snapshot was discarded
//   report_peak_hit  (MUNOC_EVMON_PEAK_EN) per-channel maximum report_hit
// -----------------------------------------------------------------------------
module munoc_event_window_monitor
  import munoc_evmon_pkg::*;
#(
  parameter int unsigned NUM_CH = DEF_NUM_CH,
  parameter int unsigned CNT_W  = DEF_CNT_W,
  parameter int unsigned WINDOW = DEF_WINDOW
) (
  input  logic                    clk,
  input  logic                    rstnn,
  input  logic                    clear,
  input  logic                    enable,
  input  logic [NUM_CH-1:0]       event_valid,
  input  logic [NUM_CH-1:0]       event_hit,
  output logic                    report_valid,
  input  logic                    report_ready,
  output logic [NUM_CH*CNT_W-1:0] report_hit,
  output logic [NUM_CH*CNT_W-1:0] report_miss,
  output logic                    report_drop
`ifdef MUNOC_EVMON_PEAK_EN
  ,
  output logic [NUM_CH*CNT_W-1:0] report_peak_hit
`endif
);

  localparam int unsigned      WIN_W    = $clog2(WINDOW);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);

  evmon_state_e r_state;
  evmon_state_e w_state_nxt;
  logic         w_advance;

  logic [WIN_W-1:0]        r_win;
  logic                    w_snap;
  logic                    w_load;
  logic                    w_drop;
  logic                    r_rv;
  logic                    r_drop;
  logic [NUM_CH*CNT_W-1:0] r_rep_hit;
  logic [NUM_CH*CNT_W-1:0] r_rep_miss;
  logic [NUM_CH*CNT_W-1:0] w_snap_hit;
  logic [NUM_CH*CNT_W-1:0] w_snap_miss;

  // ---------------------------------------------------------------------------
  // Controller. The cycle on which enable is high already counts, so leaving
  // IDLE costs no window cycle and a resumed window continues seamlessly.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn)     r_state <= ST_IDLE;
    else if (clear) r_state <= ST_IDLE;
    else            r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_advance   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (enable) begin
          w_state_nxt = ST_COUNT;
          w_advance   = 1'b1;
        end
      end
      ST_COUNT: begin
        if (!enable) w_state_nxt = ST_IDLE;
        else         w_advance   = 1'b1;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (clear) w_advance = 1'b0;
  end

  // ---------------------------------------------------------------------------
  // Window counter and report handshake
  // ---------------------------------------------------------------------------
  assign w_snap = w_advance && (r_win == WIN_LAST);
  assign w_load = w_snap && (!r_rv || report_ready);
  assign w_drop = w_snap && r_rv && !report_ready;

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      r_win <= '0;
    end else if (clear || w_snap) begin
      r_win <= '0;
    end else if (w_advance) begin
      r_win <= r_win + WIN_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      r_rv       <= 1'b0;
      r_drop     <= 1'b0;
      r_rep_hit  <= '0;
      r_rep_miss <= '0;
    end else if (clear) begin
      r_rv       <= 1'b0;
      r_drop     <= 1'b0;
      r_rep_hit  <= '0;
      r_rep_miss <= '0;
    end else begin
      if (w_load) begin
        r_rv       <= 1'b1;
        r_rep_hit  <= w_snap_hit;
        r_rep_miss <= w_snap_miss;
      end else if (report_ready) begin
        r_rv <= 1'b0;
      end
      if (w_drop) r_drop <= 1'b1;
    end
  end

  assign report_valid = r_rv;
  assign report_hit   = r_rep_hit;
  assign report_miss  = r_rep_miss;
  assign report_drop  = r_drop;

  // ---------------------------------------------------------------------------
  // Channels
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    munoc_evmon_channel #(
      .CNT_W (CNT_W)
    ) u_ch (
      .clk         (clk),
      .rstnn       (rstnn),
      .i_clear     (clear),
      .i_advance   (w_advance),
      .i_snap      (w_snap),
      .i_ev_valid  (event_valid[g]),
      .i_ev_hit    (event_hit[g]),
      .o_snap_hit  (w_snap_hit[g*CNT_W +: CNT_W]),
      .o_snap_miss (w_snap_miss[g*CNT_W +: CNT_W])
`ifdef MUNOC_EVMON_PEAK_EN
      ,
      .i_load      (w_load),
      .o_peak_hit  (report_peak_hit[g*CNT_W +: CNT_W])
`endif
    );
  end

endmodule

// File: tb/tb_munoc_event_window_monitor.sv
// -----------------------------------------------------------------------------
// tb_munoc_event_window_monitor
// Directed bench: NUM_CH=2, WINDOW=8, with a CNT_W=4 instance and a CNT_W=3
// instance sharing stimulus (the narrow one exposes saturation).
// -----------------------------------------------------------------------------
module tb_munoc_event_window_monitor;

  logic       clk = 1'b0;
  logic       rstnn;
  logic       clear;
  logic       enable;
  logic [1:0] ev_valid;
  logic [1:0] ev_hit;
  logic       ready;

  logic       rv;
  logic [7:0] hit;
  logic [7:0] miss;
  logic       drop;

  logic       s_rv;
  logic [5:0] s_hit;
  logic [5:0] s_miss;
  logic       s_drop;

`ifdef MUNOC_EVMON_PEAK_EN
  logic [7:0] peak;
  logic [5:0] s_peak;
`endif

  int unsigned n_err = 0;
  int unsigned n_chk = 0;

  always #5 clk = ~clk;

  munoc_event_window_monitor #(
    .NUM_CH (2),
    .CNT_W  (4),
    .WINDOW (8)
  ) dut (
    .clk             (clk),
    .rstnn           (rstnn),
    .clear           (clear),
    .enable          (enable),
    .event_valid     (ev_valid),
    .event_hit       (ev_hit),
    .report_valid    (rv),
    .report_ready    (ready),
    .report_hit      (hit),
    .report_miss     (miss),
    .report_drop     (drop)
`ifdef MUNOC_EVMON_PEAK_EN
    ,
    .report_peak_hit (peak)
`endif
  );

  munoc_event_window_monitor #(
    .NUM_CH (2),
    .CNT_W  (3),
    .WINDOW (8)
  ) dut_sat (
    .clk             (clk),
    .rstnn           (rstnn),
    .clear           (clear),
    .enable          (enable),
    .event_valid     (ev_valid),
    .event_hit       (ev_hit),
    .report_valid    (s_rv),
    .report_ready    (ready),
    .report_hit      (s_hit),
    .report_miss     (s_miss),
    .report_drop     (s_drop)
`ifdef MUNOC_EVMON_PEAK_EN
    ,
    .report_peak_hit (s_peak)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    rstnn    = 1'b0;
    clear    = 1'b0;
    enable   = 1'b0;
    ev_valid = 2'b00;
    ev_hit   = 2'b00;
    ready    = 1'b1;
    #12;
    n_chk++;
    if ({rv, hit, miss, drop} !== 18'h0) begin
      n_err++;
      $display("FAIL reset_outputs: got rv=%b hit=%h miss=%h drop=%b, want all 0", rv, hit, miss, drop);
    end
    rstnn = 1'b1;
    step();
    step();
    n_chk++;
    if ({rv, drop, s_rv, s_drop} !== 4'b0) begin
      n_err++;
      $display("FAIL reset_idle: got rv=%b drop=%b s_rv=%b s_drop=%b, want 0", rv, drop, s_rv, s_drop);
    end
  endtask

  task automatic test_basic();
    enable   = 1'b1;
    ready    = 1'b1;
    ev_valid = 2'b11;
    for (int i = 1; i <= 8; i++) begin
      ev_hit = {(i % 2 == 1), 1'b1};
      step();
      if (i == 7) begin
        n_chk++;
        if (rv !== 1'b0) begin
          n_err++;
          $display("FAIL basic_early: got rv=%b at edge 7, want 0", rv);
        end
      end
    end
    n_chk++;
    if (rv !== 1'b1 || hit !== 8'h48 || miss !== 8'h40) begin
      n_err++;
      $display("FAIL basic_report: got rv=%b hit=%h miss=%h, want 1 48 40", rv, hit, miss);
    end
    n_chk++;
    if (s_hit !== 6'h27 || s_miss !== 6'h20) begin
      n_err++;
      $display("FAIL saturate: got hit=%h miss=%h, want 27 20", s_hit, s_miss);
    end
    ev_valid = 2'b00;
    step();
    n_chk++;
    if (rv !== 1'b0) begin
      n_err++;
      $display("FAIL basic_pulse: got rv=%b after accept, want 0", rv);
    end
  endtask

  task automatic test_backpressure();
    do_clear();
    enable   = 1'b1;
    ready    = 1'b0;
    ev_valid = 2'b01;
    ev_hit   = 2'b01;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (i == 8) begin
        n_chk++;
        if (rv !== 1'b1 || hit !== 8'h08) begin
          n_err++;
          $display("FAIL bp_first: got rv=%b hit=%h, want 1 08", rv, hit);
        end
      end
      if (i == 15) begin
        n_chk++;
        if (drop !== 1'b0) begin
          n_err++;
          $display("FAIL bp_nodrop: got drop=%b at edge 15, want 0", drop);
        end
      end
      if (i == 16) begin
        n_chk++;
        if (drop !== 1'b1 || hit !== 8'h08 || rv !== 1'b1) begin
          n_err++;
          $display("FAIL bp_drop: got drop=%b hit=%h rv=%b, want 1 08 1", drop, hit, rv);
        end
      end
    end
    n_chk++;
    if (rv !== 1'b1 || hit !== 8'h08 || miss !== 8'h00) begin
      n_err++;
      $display("FAIL bp_hold: got rv=%b hit=%h miss=%h, want 1 08 00", rv, hit, miss);
    end
    ready    = 1'b1;
    ev_valid = 2'b00;
    step();
    n_chk++;
    if (rv !== 1'b0 || drop !== 1'b1) begin
      n_err++;
      $display("FAIL bp_accept: got rv=%b drop=%b, want 0 1", rv, drop);
    end
    step();
    step();
    step();
    n_chk++;
    if (rv !== 1'b1 || hit !== 8'h04 || drop !== 1'b1) begin
      n_err++;
      $display("FAIL bp_third: got rv=%b hit=%h drop=%b, want 1 04 1", rv, hit, drop);
    end
  endtask

  task automatic test_clear();
    ready    = 1'b0;
    ev_valid = 2'b11;
    ev_hit   = 2'b11;
    for (int i = 0; i < 5; i++) step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    n_chk++;
    if ({rv, hit, miss, drop} !== 18'h0) begin
      n_err++;
      $display("FAIL clear_zero: got rv=%b hit=%h miss=%h drop=%b, want all 0", rv, hit, miss, drop);
    end
    ready    = 1'b1;
    ev_valid = 2'b11;
    for (int i = 1; i <= 8; i++) begin
      ev_hit = {1'b0, (i <= 3)};
      step();
      if (i == 7) begin
        n_chk++;
        if (rv !== 1'b0) begin
          n_err++;
          $display("FAIL clear_early: got rv=%b at edge 7, want 0", rv);
        end
      end
    end
    n_chk++;
    if (rv !== 1'b1 || hit !== 8'h03 || miss !== 8'h85) begin
      n_err++;
      $display("FAIL clear_report: got rv=%b hit=%h miss=%h, want 1 03 85", rv, hit, miss);
    end
  endtask

  task automatic test_enable_gap();
    do_clear();
    ready    = 1'b1;
    ev_valid = 2'b01;
    ev_hit   = 2'b01;
    for (int i = 1; i <= 11; i++) begin
      enable = !(i >= 4 && i <= 6);
      step();
      if (i == 10) begin
        n_chk++;
        if (rv !== 1'b0) begin
          n_err++;
          $display("FAIL gap_early: got rv=%b at cycle 10, want 0", rv);
        end
      end
    end
    n_chk++;
    if (rv !== 1'b1 || hit !== 8'h08 || miss !== 8'h00) begin
      n_err++;
      $display("FAIL gap_report: got rv=%b hit=%h miss=%h, want 1 08 00", rv, hit, miss);
    end
    enable = 1'b1;
  endtask

  task automatic test_back_to_back();
    do_clear();
    ready    = 1'b1;
    enable   = 1'b1;
    ev_valid = 2'b11;
    ev_hit   = 2'b01;
    for (int i = 1; i <= 16; i++) begin
      step();
      if (i == 8 || i == 16) begin
        n_chk++;
        if (rv !== 1'b1 || hit !== 8'h08 || miss !== 8'h80 || drop !== 1'b0) begin
          n_err++;
          $display("FAIL b2b_report: edge %0d got rv=%b hit=%h miss=%h drop=%b, want 1 08 80 0", i, rv, hit, miss, drop);
        end
      end
      if (i == 9) begin
        n_chk++;
        if (rv !== 1'b0) begin
          n_err++;
          $display("FAIL b2b_gap: got rv=%b at edge 9, want 0", rv);
        end
      end
    end
  endtask

`ifdef MUNOC_EVMON_PEAK_EN
  task automatic test_peak();
    int unsigned nh[3]   = '{3, 6, 2};
    logic [3:0]  want[3] = '{4'd3, 4'd6, 4'd6};
    do_clear();
    ready    = 1'b1;
    enable   = 1'b1;
    ev_valid = 2'b01;
    for (int w = 0; w < 3; w++) begin
      for (int c = 1; c <= 8; c++) begin
        ev_hit = {1'b0, (c <= nh[w])};
        step();
      end
      n_chk++;
      if (peak[3:0] !== want[w]) begin
        n_err++;
        $display("FAIL peak_w%0d: got %0d, want %0d", w, peak[3:0], want[w]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_clear();
    test_enable_gap();
    test_back_to_back();
`ifdef MUNOC_EVMON_PEAK_EN
    test_peak();
`endif
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/munoc_event_window_monitor.md
# munoc_event_window_monitor

Multi-channel windowed event monitor for µNoC performance observation. Each channel classifies qualified events as hit or miss and counts both into saturating counters over a fixed-length window of enabled cycles. At window end the counts are snapshotted into a report register, offered with a valid/ready handshake, and the counters restart. This block generalises the single-channel fixed-window hit/miss monitor to NUM_CH channels, adds report back-pressure with drop detection, and adds enable/clear control.

## Interface
- NUM_CH, 4, number of independent event channels (≥1)
- CNT_W, 16, width of each hit/miss counter
- WINDOW, 500, window length in enabled cycles (≥2)
- clk  in  1  clock
- rstnn  in  1  asynchronous active-low reset
- clear  in  1  synchronous clear of all state
- enable  in  1  window and counters advance only when high
- event_valid  in  NUM_CH  per-channel event qualifier
- event_hit  in  NUM_CH  per-channel class: 1=hit, 0=miss (ignored when valid=0)
- report_valid  out  1  snapshot available
- report_ready  in  1  consumer accepts snapshot
- report_hit  out  NUM_CH*CNT_W  hit counts, channel i at [i*CNT_W +: CNT_W]
- report_miss  out  NUM_CH*CNT_W  miss counts, same packing
- report_drop  out  1  sticky: a snapshot was discarded
- report_peak_hit  out  NUM_CH*CNT_W  per-channel maximum report_hit (only with MUNOC_EVMON_PEAK_EN)

## Operation
- Reset (rstnn=0): window counter, all counters, report_valid, report_hit, report_miss, report_drop, report_peak_hit = 0. State IDLE.
- States: IDLE (enable=0), COUNT (enable=1). IDLE→COUNT when enable=1; COUNT→IDLE when enable=0. IDLE holds window counter and counts frozen; events are ignored. Resume continues the same window.
- In COUNT, per channel: valid&hit increments hit, valid&~hit increments miss. Counters saturate at 2^CNT_W−1, never wrap.
- Window counter width $clog2(WINDOW), counts 0..WINDOW−1. On the cycle it equals WINDOW−1 (enabled): snapshot = counter value plus that cycle's event; counters and window counter reload to 0.
- Report register: loads on snapshot if report_valid=0 or report_ready=1 in the same cycle (simultaneous accept+load keeps report_valid=1 with new data). If report_valid=1 and report_ready=0 at snapshot: new snapshot discarded, old report held, report_drop set.
- Handshake: transfer when report_valid&report_ready; report_valid falls next cycle unless reloaded. Data stable while report_valid=1 and not accepted.
- clear: highest priority below reset; zeroes everything that reset zeroes, including report_drop and peaks, within one cycle; events in the clear cycle are not counted.

## Timing
- Event at enabled cycle t is visible in internal counter after edge t.
- First report: report_valid rises at the edge ending the WINDOW-th enabled cycle after reset/clear.
- Minimum report spacing WINDOW enabled cycles; report_ready may be held high continuously.
- No combinational path from inputs to outputs.

## Configuration
- MUNOC_EVMON_PEAK_EN defined: report_peak_hit port and per-channel peak registers exist; on each report load, peak_i = max(peak_i, new hit_i) — including loads that are later dropped? No: only loaded snapshots update peaks. Cleared by reset/clear.
- Undefined: port and registers absent; all other behaviour identical.

## Structure
- Shared package munoc_evmon_pkg: state encoding (IDLE, COUNT), default parameter constants, saturating-increment function.
- Sub-module munoc_evmon_channel: one channel's hit/miss saturating counters, snapshot outputs and optional peak register; instantiated NUM_CH times in a generate loop. Top holds FSM, window counter, report register and handshake.

## Test plan
- NUM_CH=2, CNT_W=4, WINDOW=8, ready=1; ch0 valid&hit every cycle, ch1 alternating hit/miss -> report hit={4,8}, miss={4,0} (ch1,ch0), report_valid one cycle at edge 8.
- CNT_W=3, WINDOW=8, ch0 hit every cycle -> report hit[0]=7 (saturated), no wrap.
- ready=0 for 20 enabled cycles -> first report held unchanged, report_drop=1 after edge 16; ready=1 -> transfer, drop stays 1 until clear.
- 5 hits then clear mid-window -> all outputs 0 next cycle; next report after 8 further enabled cycles with only post-clear events.
- enable low 3 cycles inside window, ch0 hits whenever enabled -> report after 11 cycles, hit[0]=8.
- With MUNOC_EVMON_PEAK_EN: window hits 3, 6, 2 on ch0 -> report_peak_hit[0] = 3, 6, 6.
